// File: rtl/regfile_pkg.sv
// Shared defaults and packing helper for the multi-port register file.
// The top and the read-port sub-module both import this package.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // LSB position of port 'port' inside a packed bus of 'width'-bit slices
  function automatic int pack_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address compare, write-first bypass, zero-register gating.
// Array data and next-cycle busy state are selected by the parent and handed in here.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] array_data,
  input  logic              busy_next,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic              bypass_hit;
  logic              zero_hit;
  logic [DATA_W-1:0] data_d;
  logic              busy_d;

  assign bypass_hit = wr_en && (wr_addr == rd_addr);
  assign zero_hit   = (ZERO_REG != 0) && (rd_addr == '0);

  // zero gating overrides bypass so a discarded write to r0 never leaks out
  always_comb begin
    data_d = array_data;
    busy_d = busy_next;
    if (bypass_hit) begin
      data_d = wr_data;
    end
    if (zero_hit) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else begin
      rd_data <= data_d;
      rd_busy <= busy_d;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with per-register pending (busy) scoreboard.
// The array and scoreboard live here; each read port is a regfile_read_port instance.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_eff;

  assign wr_eff = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // reservation is applied after the write-clear so a same-address pair stays busy
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] port_addr;

    assign port_addr = rd_addr[pack_lsb(i, ADDR_W) +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr    (port_addr),
      .array_data (regs[port_addr]),
      .busy_next  (busy_d[port_addr]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[pack_lsb(i, DATA_W) +: DATA_W]),
      .rd_busy    (rd_busy[i])
    );
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write strobe.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rsv_en  in  1  reserve strobe; marks destination pending.
REQ-012 rsv_addr  in  ADDR_W  register to reserve.
REQ-013 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 rd_data  out  NUM_RD*DATA_W  packed registered read data, same packing.
REQ-015 rd_busy  out  NUM_RD  registered pending flag per read port.

Function
REQ-016 Write: on clk rise with wr_en=1, reg[wr_addr] SHALL take wr_data; wr_en=0 leaves the array unchanged.
REQ-017 Read latency SHALL be exactly 1 cycle: rd_data port i after edge N reflects rd_addr port i sampled at edge N.
REQ-018 Write-first bypass: if wr_en=1 and wr_addr equals rd_addr port i at the same edge, rd_data port i SHALL take wr_data, not the old contents.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0, including under bypass.
REQ-020 With ZERO_REG=0, address 0 SHALL behave as an ordinary register.
REQ-021 Scoreboard: one busy bit per register; rsv_en=1 SHALL set busy[rsv_addr]; wr_en=1 SHALL clear busy[wr_addr].
REQ-022 Same-edge rsv_en and wr_en to the same address: set SHALL win; busy stays 1 and data is still written.
REQ-023 Same-edge rsv_en and wr_en to different addresses SHALL both take effect.
REQ-024 With ZERO_REG=1, busy[0] SHALL never be set.
REQ-025 rd_busy port i after edge N SHALL equal busy[rd_addr i] after the edge-N updates (REQ-021..024 applied).
REQ-026 Any number of read ports MAY address the same register; each SHALL return identical data and busy.
REQ-027 Re-reserving an already busy register SHALL leave it busy (no counting).
REQ-028 A write to a non-busy register SHALL be accepted normally; busy stays 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without clk, clear all DEPTH registers, all busy bits, rd_data and rd_busy to 0.
REQ-030 While rst_n=0, wr_en and rsv_en SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard any write or reservation at that edge; the first effective edge is the first rising clk with rst_n=1.

Structure
REQ-032 Package regfile_pkg SHALL hold default DATA_W, ADDR_W and NUM_RD constants and the packing-offset helper.
REQ-033 Sub-module regfile_read_port (address compare, bypass mux, zero-reg gating, output registers) SHALL be instantiated NUM_RD times by generate.
REQ-034 The array and scoreboard SHALL reside in register_file_mp; no latches; no delay constructs.

Verification
REQ-035 Reset then read all 32 addresses on 2 ports -> rd_data=0, rd_busy=0 one cycle later.
REQ-036 Write 0xDEADBEEF to r5, next cycle read r5 -> rd_data=0xDEADBEEF after 1 cycle; same-cycle write 0x12345678 to r7 with read r7 -> 0x12345678 (bypass).
REQ-037 Write 0xFFFFFFFF to r0 and read r0 same cycle and later -> rd_data=0 (ZERO_REG=1); with ZERO_REG=0 -> 0xFFFFFFFF.
REQ-038 Reserve r3, read r3 -> rd_busy=1; write r3=0xA5 -> rd_busy=0, data 0xA5; reserve and write r3 same edge -> rd_busy=1, data updated.
REQ-039 Fill r1..r31 with index values, drop rst_n low between clk edges -> all outputs 0 immediately; post-reset reads return 0.
REQ-040 Rerun REQ-036 with DATA_W=64, ADDR_W=4, NUM_RD=4, all ports reading the same address -> identical data on all four ports.
